jtag_dr_bridge: RTL
===================

Name: jtag_dr_bridge

Overview:
- Parametrised JTAG user-DR transport between the BSCAN user-register signals and the puzzle core. Runs entirely in the tck domain.
- Inbound: any DR scan is sliced into IN_WIDTH-bit words, LSB first. Words are buffered in a FIFO and presented on a valid/ready stream. A scan may carry one word or many back-to-back words.
- Outbound: capture_dr snapshots the core result plus sticky status bits. These are shifted out on tdo LSB first.
- Successor to the fixed 8-bit-in / 32-bit-out user logic front-end. Adds buffering, multi-word scans, framing/overflow detection and a status readback.

Parameters:
- IN_WIDTH, 8, inbound word width in bits (>=2).
- OUT_WIDTH, 32, result width in bits.
- FIFO_DEPTH, 16, inbound FIFO entries (power of two, >=2).

Ports:
- tck  in  1  JTAG TCK; sole clock, all flops on posedge.
- test_logic_reset_n  in  1  reset, asynchronous assert, active-low.
- tdi  in  1  serial data in.
- tdo  out  1  serial data out; registered.
- ir_is_user  in  1  IR selects this user register; gates all DR activity.
- capture_dr  in  1  TAP in Capture-DR.
- shift_dr  in  1  TAP in Shift-DR.
- update_dr  in  1  TAP in Update-DR.
- in_data  out  IN_WIDTH  inbound word, FIFO head.
- in_valid  out  1  FIFO non-empty.
- in_ready  in  1  core accepts in_data this cycle.
- result_data  in  OUT_WIDTH  core result.
- result_valid  in  1  result_data is final.

Behaviour:
Reset (async, test_logic_reset_n=0):
- FIFO empty, so in_valid=0 and in_data=0.
- tdo=0; shift registers, bit counter and sticky flags cleared.
- A reset mid-scan discards the partial word. Scanning resumes cleanly at the next capture_dr.

Gating:
- capture_dr, shift_dr and update_dr act only when ir_is_user=1. Otherwise no state changes except the FIFO pop side.

Inbound path:
- capture_dr clears bit_cnt.
- Each shift_dr cycle: in_sr <= {tdi, in_sr[IN_WIDTH-1:1]} and bit_cnt increments, wrapping at IN_WIDTH.
- On the shift cycle where bit_cnt==IN_WIDTH-1, the completed word {tdi, in_sr[IN_WIDTH-1:1]} is pushed and bit_cnt returns to 0.
- Push timing: in_valid rises the next cycle when the FIFO was empty. There is no combinational bypass.
- Full FIFO: a push is dropped and sticky ovf is set. Exception: a push coinciding with a pop while full is accepted.
- update_dr with bit_cnt!=0: the trailing partial word is discarded, sticky ferr is set, and bit_cnt is cleared.
- Pop: in_valid && in_ready pops in FIFO order. in_data always reflects the head entry.

Outbound path:
- Frame register out_sr is OUT_WIDTH+2 bits.
- On capture_dr, out_sr <= {ferr, ovf, result_valid ? result_data : 0}.
- On shift_dr, out_sr <= {1'b0, out_sr[OUT_WIDTH+1:1]}.
- tdo is registered: the flop is loaded with the out_sr bit that becomes the LSB in that same posedge, i.e. the next value of out_sr[0]. tdo therefore presents bit 0 right after capture and is stable for negedge sampling.
- A scan of exactly OUT_WIDTH bits returns only the result, which keeps the host polling script unchanged. Bit OUT_WIDTH is ovf, bit OUT_WIDTH+1 is ferr.
- Sticky flags clear on capture_dr (read-to-clear). A set event in the same cycle wins, and the flag stays 1.

Simultaneous events:
- capture_dr, shift_dr and update_dr are mutually exclusive by TAP construction. No priority between them is required.

Decomposition:
- jtag_bridge_pkg:
  - status bit indices STAT_OVF=0 and STAT_FERR=1, relative to OUT_WIDTH;
  - a localparam function giving the counter width, $clog2(IN_WIDTH);
  - the frame width constant OUT_WIDTH+2.
- Sub-module jtag_word_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, push_data, pop, head, empty, full.
  - Async active-low reset; accepts push on full when pop is asserted in the same cycle.

Test Plan:
1. One 24-bit scan of "AB\n" (0x41,0x42,0x0A LSB first), in_ready=1 -> three in_valid beats: 0x41, 0x42, 0x0A, in order; ferr=0.
2. 12-bit scan of 0x41 followed by 4 bits 0xF -> one word 0x41; next 34-bit readback shows bit33 (ferr)=1; a second readback shows bit33=0.
3. in_ready=0, 17 single-byte scans of 0x30..0x40 -> 16 entries held; 34-bit readback bit32 (ovf)=1; draining yields 0x30..0x3F.
4. result_valid=0 -> 32-bit readback = 0. Then result_data=0x00001234 with result_valid=1 -> readback = 0x00001234, bits 33:32 = 0.
5. test_logic_reset_n pulsed low after 5 shift bits -> no push, in_valid=0, tdo=0; a following full 8-bit scan of 0x0A pushes exactly 0x0A.
6. ir_is_user=0 during an 8-bit scan of 0x55 plus update -> no push, no ferr; tdo stays 0.

Source files
------------

// File: rtl/jtag_bridge_pkg.sv
// Shared constants and helpers for the JTAG user-DR bridge: status bit
// positions within the outbound frame and width helpers.
package jtag_bridge_pkg;

  localparam int STAT_OVF  = 0;
  localparam int STAT_FERR = 1;

  typedef struct packed {
    logic ferr;
    logic ovf;
  } status_t;

  function automatic int cnt_width(input int in_width);
    return (in_width > 1) ? $clog2(in_width) : 1;
  endfunction

  function automatic int frame_width(input int out_width);
    return out_width + 2;
  endfunction

endpackage

// File: rtl/jtag_word_fifo.sv
// Synchronous word FIFO. A push while full is still taken when a pop
// frees the head slot in the same cycle.
module jtag_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/jtag_dr_bridge.sv
// JTAG user-DR transport in the tck domain: slices inbound scans into words
// for the core and shifts out result plus sticky status on tdo.
module jtag_dr_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 tck,
  input  logic                 test_logic_reset_n,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic                 ir_is_user,
  input  logic                 capture_dr,
  input  logic                 shift_dr,
  input  logic                 update_dr,
  output logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_valid,
  input  logic                 in_ready,
  input  logic [OUT_WIDTH-1:0] result_data,
  input  logic                 result_valid
);

  localparam int CW = cnt_width(IN_WIDTH);
  localparam int FW = frame_width(OUT_WIDTH);

  logic                cap, sh, upd;
  logic [IN_WIDTH-1:0] in_sr_q, in_sr_d, word;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                last_bit, push, pop, empty, full;
  status_t             stat_q, stat_d;
  logic [FW-1:0]       out_sr_q, out_sr_d;
  logic                tdo_q;

  assign cap      = ir_is_user & capture_dr;
  assign sh       = ir_is_user & shift_dr;
  assign upd      = ir_is_user & update_dr;
  assign word     = {tdi, in_sr_q[IN_WIDTH-1:1]};
  assign last_bit = (bit_cnt_q == CW'(IN_WIDTH-1));
  assign push     = sh & last_bit;
  assign pop      = ~empty & in_ready;
  assign in_valid = ~empty;
  assign tdo      = tdo_q;

  always_comb begin
    in_sr_d   = in_sr_q;
    bit_cnt_d = bit_cnt_q;
    stat_d    = stat_q;
    out_sr_d  = out_sr_q;
    if (cap) begin
      bit_cnt_d = '0;
      stat_d    = '0;
      out_sr_d  = '0;
      out_sr_d[OUT_WIDTH-1:0]          = result_valid ? result_data : '0;
      out_sr_d[OUT_WIDTH + STAT_OVF]   = stat_q.ovf;
      out_sr_d[OUT_WIDTH + STAT_FERR]  = stat_q.ferr;
    end
    if (sh) begin
      in_sr_d   = word;
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
      out_sr_d  = {1'b0, out_sr_q[FW-1:1]};
    end
    if (upd) bit_cnt_d = '0;
    // Set events override the read-to-clear on capture.
    if (push & full & ~pop)        stat_d.ovf  = 1'b1;
    if (upd && bit_cnt_q != '0)    stat_d.ferr = 1'b1;
  end

  always_ff @(posedge tck or negedge test_logic_reset_n) begin
    if (!test_logic_reset_n) begin
      in_sr_q   <= '0;
      bit_cnt_q <= '0;
      stat_q    <= '0;
      out_sr_q  <= '0;
      tdo_q     <= 1'b0;
    end else begin
      in_sr_q   <= in_sr_d;
      bit_cnt_q <= bit_cnt_d;
      stat_q    <= stat_d;
      out_sr_q  <= out_sr_d;
      tdo_q     <= out_sr_d[0];
    end
  end

  jtag_word_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (tck),
    .rst_n     (test_logic_reset_n),
    .push      (push),
    .push_data (word),
    .pop       (pop),
    .head      (in_data),
    .empty     (empty),
    .full      (full)
  );

endmodule
